// File: rtl/laser_cover_scorer_pkg.sv
// Shared constants, point record and scorer state encoding for the
// two-circle laser cover scorer.
package laser_pkg;

  localparam int NPTS = 40;
  localparam int CW   = 4;
  localparam int R2   = 16;
  localparam int SW   = 6;
  localparam int PW   = $clog2(NPTS);

  localparam logic [2*CW:0] R2_W     = (2*CW+1)'(R2);
  localparam logic [PW-1:0] PTR_LAST = PW'(NPTS - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(NPTS - 1);

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } point_t;

  typedef enum logic {
    IDLE,
    SCORE
  } state_t;

endpackage

// File: rtl/laser_cover_scorer_if.sv
// Point stream, solver result snoop and score reporting bundle.
interface laser_cover_scorer_if;

  logic                      IN_VALID;
  logic [laser_pkg::CW-1:0]  X;
  logic [laser_pkg::CW-1:0]  Y;
  logic                      DONE;
  logic [laser_pkg::CW-1:0]  C1X;
  logic [laser_pkg::CW-1:0]  C1Y;
  logic [laser_pkg::CW-1:0]  C2X;
  logic [laser_pkg::CW-1:0]  C2Y;
  logic [laser_pkg::SW-1:0]  SCORE;
  logic                      SCORE_VALID;
  logic                      BUSY;
  logic                      ERR;
  logic                      OVF;

  modport master (
    output IN_VALID, X, Y, DONE, C1X, C1Y, C2X, C2Y,
    input  SCORE, SCORE_VALID, BUSY, ERR, OVF
  );

  modport slave (
    input  IN_VALID, X, Y, DONE, C1X, C1Y, C2X, C2Y,
    output SCORE, SCORE_VALID, BUSY, ERR, OVF
  );

endinterface

// File: rtl/laser_cover_scorer_in_circle.sv
// Combinational membership test: is (px,py) within radius sqrt(R2) of (cx,cy).
module laser_in_circle
  import laser_pkg::*;
(
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  output logic          in
);

  logic [CW-1:0]   dx;
  logic [CW-1:0]   dy;
  logic [2*CW-1:0] sx;
  logic [2*CW-1:0] sy;
  logic [2*CW:0]   d;

  // Full-width squares and sum so no distance aliases back under the threshold.
  always_comb begin
    dx = (px >= cx) ? (px - cx) : (cx - px);
    dy = (py >= cy) ? (py - cy) : (cy - py);
    sx = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    sy = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    d  = {1'b0, sx} + {1'b0, sy};
    in = (d <= R2_W);
  end

endmodule

// File: rtl/laser_cover_scorer.sv
// Snoops the solver's point stream into a ping-pong buffer and, on each
// solver DONE edge, counts points covered by either reported circle.
//
//   state | meaning
//   IDLE  | waiting for a DONE rising edge
//   SCORE | walking the oldest full bank, one point per cycle
module laser_cover_scorer
  import laser_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  laser_cover_scorer_if.slave  bus
);

  point_t        bank [2][NPTS];
  logic [PW-1:0] ptr;
  logic          ld_bank;
  logic          sc_bank;
  logic [1:0]    full;
  logic          ovf;
  logic          done_q;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] idx;
  logic [SW-1:0] acc;
  logic [SW-1:0] score_q;
  logic          score_valid;
  logic          err;
  logic [CW-1:0] c1x, c1y, c2x, c2y;

  logic          done_rise;
  logic          wr_ok;
  logic          wr_last;
  logic          last_pt;
  logic          start;
  logic          fire_err;
  logic          busy;
  logic          hit1;
  logic          hit2;
  logic          hit;
  point_t        pt;

  assign done_rise = bus.DONE & ~done_q;
  assign wr_ok     = bus.IN_VALID & ~full[ld_bank];
  assign wr_last   = wr_ok && (ptr == PTR_LAST);
  assign last_pt   = (state == SCORE) && (idx == IDX_LAST);
  assign pt        = bank[sc_bank][idx];
  assign hit       = hit1 | hit2;

  laser_in_circle u_in_c1 (.px(pt.x), .py(pt.y), .cx(c1x), .cy(c1y), .in(hit1));
  laser_in_circle u_in_c2 (.px(pt.x), .py(pt.y), .cx(c2x), .cy(c2y), .in(hit2));

  always_ff @(posedge CLK) begin
    if (wr_ok) bank[ld_bank][ptr] <= '{x: bus.X, y: bus.Y};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr     <= '0;
      ld_bank <= 1'b0;
      ovf     <= 1'b0;
    end else if (bus.IN_VALID) begin
      if (full[ld_bank]) begin
        ovf <= 1'b1;
      end else if (ptr == PTR_LAST) begin
        ptr     <= '0;
        ld_bank <= ~ld_bank;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // A filling bank is never full and the scored bank always is, so set and
  // clear never target the same bit in one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_last && (ld_bank == 1'(b)))      full[b] <= 1'b1;
        else if (last_pt && (sc_bank == 1'(b))) full[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (done_rise && full[sc_bank]) state_nx = SCORE;
      SCORE:   if (last_pt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == SCORE);
    start    = (state == IDLE) && done_rise && full[sc_bank];
    fire_err = (state == IDLE) && done_rise && !full[sc_bank];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done_q      <= 1'b1;
      idx         <= '0;
      acc         <= '0;
      c1x         <= '0;
      c1y         <= '0;
      c2x         <= '0;
      c2y         <= '0;
      sc_bank     <= 1'b0;
      score_q     <= '0;
      score_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      done_q      <= bus.DONE;
      score_valid <= 1'b0;
      err         <= fire_err;
      if (start) begin
        c1x <= bus.C1X;
        c1y <= bus.C1Y;
        c2x <= bus.C2X;
        c2y <= bus.C2Y;
        idx <= '0;
        acc <= '0;
      end else if (state == SCORE) begin
        idx <= idx + 1'b1;
        acc <= acc + SW'(hit);
        if (last_pt) begin
          score_q     <= acc + SW'(hit);
          score_valid <= 1'b1;
          sc_bank     <= ~sc_bank;
        end
      end
    end
  end

  assign bus.SCORE       = score_q;
  assign bus.SCORE_VALID = score_valid;
  assign bus.BUSY        = busy;
  assign bus.ERR         = err;
  assign bus.OVF         = ovf;

endmodule

// File: doc/laser_cover_scorer.md
Name: laser_cover_scorer

Overview:
- Downstream checker/scorer for the two-circle laser solver. Snoops the same 40-point X/Y stream the solver consumes and stores it in a ping-pong point buffer.
- On each solver DONE, scores the reported centres C1/C2: counts points covered by either circle, radius 4, with dx²+dy² <= 16.
- Result feeds host-side comparison and regression logging.

Parameters:
- NPTS, 40, points per frame.
- CW, 4, coordinate width.
- R2, 16, inclusion threshold on dx²+dy².
- SW, 6, score width; must satisfy 2^SW > NPTS.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  X/Y hold a valid point this cycle.
- X  in  CW  point x.
- Y  in  CW  point y.
- DONE  in  1  solver done; level signal; only its rising edge is used.
- C1X, C1Y, C2X, C2Y  in  CW each  solver centres; sampled in the cycle DONE rises.
- SCORE  out  SW  covered-point count of the last scored frame.
- SCORE_VALID  out  1  one-cycle pulse when SCORE updates.
- BUSY  out  1  scorer FSM in SCORE state.
- ERR  out  1  one-cycle pulse: DONE rose with no full bank.
- OVF  out  1  sticky: a point was dropped because both banks were full.

Behaviour:
- Reset (async): SCORE=0, SCORE_VALID=0, BUSY=0, ERR=0, OVF=0, both banks empty, load bank=0, load pointer=0, done_q=1. Because done_q resets to 1, a DONE held high out of reset is not treated as an edge.
- Load path runs independently of the scorer FSM.
  - Each IN_VALID cycle writes (X,Y) to bank[ld_bank][ptr] and increments ptr.
  - On the NPTS-th write: ptr->0, full[ld_bank]<=1, ld_bank toggles.
  - IN_VALID while full[ld_bank]=1: point dropped, OVF<=1 (sticky until RST), ptr unchanged.
- Banks are scored in fill order. sc_bank is the oldest full bank and toggles after each score.
- Edge detect: done_rise = DONE & ~done_q, where done_q is DONE registered every cycle.
- FSM states:
  - IDLE: on done_rise with full[sc_bank]=1, latch the four centres, idx<=0, acc<=0, go to SCORE.
  - IDLE: on done_rise with no full bank, ERR pulses one cycle and the FSM stays in IDLE.
  - SCORE: one point per cycle, idx 0..NPTS-1. hit = (d1 <= R2) | (d2 <= R2), where d = |px-cx|²+|py-cy|².
    - |diff| is CW bits; each square is 2*CW bits; the sum is 2*CW+1 bits. No truncation.
    - A point covered by both circles counts once.
    - acc <= acc + hit.
  - SCORE at idx=NPTS-1: SCORE <= acc+hit, SCORE_VALID<=1, full[sc_bank]<=0, sc_bank toggles, go to IDLE.
- Latency: with done_rise sampled at edge e0, SCORE_VALID is high during the cycle after edge e0+NPTS (e40), for exactly one cycle.
- BUSY=1 exactly while the FSM is in SCORE.
- Loading the other bank during SCORE is legal.
- A write completing into the bank being scored cannot occur: that bank is still full, so the write is dropped and OVF sets.
- done_rise during SCORE: ignored; no ERR, centres not re-latched.
- Simultaneous 40th write and done_rise on an otherwise empty state: the full bit is not yet visible, so ERR pulses. Upstream guarantees DONE rises at least one cycle after the last point.
- SCORE holds its value between pulses.
- RST mid-SCORE: abort; no SCORE_VALID; all state returns to reset values.

Decomposition:
- Shared package laser_pkg holds:
  - constants NPTS, CW, R2, SW;
  - point typedef {x[CW], y[CW]};
  - scorer state enum {IDLE, SCORE}.
- One sub-module, laser_in_circle: combinational; (px,py,cx,cy) -> in = dx²+dy² <= R2. Instantiated twice, once per centre.

Test Plan:
- 40 points all (8,8); DONE rises with C1=(8,8), C2=(0,0) -> SCORE_VALID pulse after edge e40, SCORE=40, BUSY high 40 cycles.
- 20 points (0,0) + 20 points (15,15):
  - C1=(0,0), C2=(15,15) -> SCORE=40.
  - Next frame, same points, C1=C2=(0,0) -> SCORE=20 (overlap counted once).
- Boundary, centre (0,0) with C2=(15,15): points (4,0) in (16), (2,3) in (13), (3,3) out (18), (0,5) out (25), the rest (15,0) out -> SCORE=2.
- DONE rises with no complete frame loaded -> one-cycle ERR, no SCORE_VALID, BUSY stays 0.
- Back-to-back frames, with frame B streamed during frame A's SCORE -> two correct scores in order, OVF=0. A third frame streamed before either score -> OVF=1, third frame's points dropped.
- RST asserted at idx=20 of SCORE -> SCORE=0, no SCORE_VALID, BUSY=0. A later DONE without a reload -> ERR.
